// File: rtl/bcd_serial_if.sv
// Handshake bundle for bcd_serial: input valid/ready/data and output valid/ready/result.
interface bcd_serial_if #(
   parameter int BIN_W  = 9,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, bcd_out, ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, bcd_out, ovf
   );
endinterface

// File: rtl/bcd_serial.sv
// Iterative binary-to-BCD converter (double dabble), one bit per clock, sticky overflow.
// Optional leading-zero blanking (digits read 4'hF) when BCD_BLANK_EN is defined.
module bcd_serial #(
   parameter int BIN_W  = 9,
   parameter int DIGITS = 3,
   parameter int CNT_W  = $clog2(BIN_W + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   bcd_serial_if.slave  io
);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   acc_q, acc_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic               vld_q, vld_d;
   logic [BCD_W-1:0]   corr;
   logic [BCD_W-1:0]   acc_sh;

`ifdef BCD_BLANK_EN
   function automatic logic [BCD_W-1:0] blank(input logic [BCD_W-1:0] v);
      logic lead;
      blank = v;
      lead  = 1'b1;
      for (int unsigned i = DIGITS - 1; i > 0; i--) begin
         if (lead && (v[4*i +: 4] == 4'd0)) blank[4*i +: 4] = 4'hF;
         else                               lead = 1'b0;
      end
   endfunction
`else
   function automatic logic [BCD_W-1:0] blank(input logic [BCD_W-1:0] v);
      blank = v;
   endfunction
`endif

   // Add-3 correction precedes the shift within the same cycle
   always_comb begin
      corr = acc_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      acc_sh = {corr[BCD_W-2:0], bin_q[BIN_W-1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      vld_d   = vld_q;
      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               bin_d   = io.in_data;
               acc_d   = '0;
               cnt_d   = CNT_W'(BIN_W);
               ovf_d   = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bin_d = bin_q << 1;
            acc_d = acc_sh;
            ovf_d = ovf_q | corr[BCD_W-1];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               vld_d   = 1'b1;
               bcd_d   = blank(acc_sh);
            end
         end
         DONE: begin
            if (io.out_ready) begin
               state_d = IDLE;
               vld_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         vld_q   <= vld_d;
      end
   end

   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = vld_q;
   assign io.bcd_out   = bcd_q;
   assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_serial.sv
// Directed-vector bench for bcd_serial: 3-digit, 2-digit (overflow) and 1-bit instances.
module tb_bcd_serial;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bcd_serial_if #(.BIN_W(9), .DIGITS(3)) a ();
   bcd_serial_if #(.BIN_W(9), .DIGITS(2)) b ();
   bcd_serial_if #(.BIN_W(1), .DIGITS(1)) c ();

   bcd_serial #(.BIN_W(9), .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .io(a));
   bcd_serial #(.BIN_W(9), .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .io(b));
   bcd_serial #(.BIN_W(1), .DIGITS(1)) u_c (.clk(clk), .rst_n(rst_n), .io(c));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit sweep_on = 1'b0;
   int last_acc = -1;
   int min_gap = 100000;
   logic [12:0] out_obs[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sweep_on) begin
         if (a.in_valid && a.in_ready) begin
            if (last_acc >= 0 && (cyc - last_acc) < min_gap) min_gap = cyc - last_acc;
            last_acc = cyc;
         end
         if (a.out_valid && a.out_ready) out_obs.push_back({a.ovf, a.bcd_out});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] model3(input int v);
      logic [3:0] d2, d1, d0;
      d2 = 4'(v / 100);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
`ifdef BCD_BLANK_EN
      if (d2 == 4'd0) begin
         d2 = 4'hF;
         if (d1 == 4'd0) d1 = 4'hF;
      end
`endif
      return {d2, d1, d0};
   endfunction

   task automatic drive(input int w, input logic iv, input logic [8:0] d, input logic orr);
      case (w)
         0: begin a.in_valid = iv; a.in_data = d;    a.out_ready = orr; end
         1: begin b.in_valid = iv; b.in_data = d;    b.out_ready = orr; end
         default: begin c.in_valid = iv; c.in_data = d[0]; c.out_ready = orr; end
      endcase
   endtask

   function automatic logic get_ir(input int w);
      return (w == 0) ? a.in_ready : (w == 1) ? b.in_ready : c.in_ready;
   endfunction
   function automatic logic get_ov(input int w);
      return (w == 0) ? a.out_valid : (w == 1) ? b.out_valid : c.out_valid;
   endfunction
   function automatic logic get_ovf(input int w);
      return (w == 0) ? a.ovf : (w == 1) ? b.ovf : c.ovf;
   endfunction
   function automatic logic [11:0] get_bcd(input int w);
      return (w == 0) ? a.bcd_out : (w == 1) ? {4'h0, b.bcd_out} : {8'h0, c.bcd_out};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (sweep_on) a.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // One full transaction: returns result, ovf, latency in edges after acceptance
   task automatic conv(input int w, input logic [8:0] v, input int stall,
                       output logic [11:0] res, output logic o, output int lat, output bit busy);
      int g;
      drive(w, 1'b1, v, 1'b0);
      g = 0;
      while (!get_ir(w) && g < 100) begin @(posedge clk); #1; g++; end
      @(posedge clk); #1;
      drive(w, 1'b0, ~v, 1'b0);
      lat  = 0;
      busy = 1'b0;
      while (!get_ov(w) && lat < 100) begin
         if (get_ir(w)) busy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      res = get_bcd(w);
      o   = get_ovf(w);
      repeat (stall) begin @(posedge clk); #1; end
      drive(w, 1'b0, 9'd0, 1'b1);
      @(posedge clk); #1;
      drive(w, 1'b0, 9'd0, 1'b0);
   endtask

   typedef struct {
      logic [8:0]  din;
      logic [11:0] plain;
      logic [11:0] blank;
   } vec3_t;

   typedef struct {
      logic [8:0] din;
      logic [7:0] plain;
      logic [7:0] blank;
      logic       ovf;
   } vec2_t;

   initial begin
      vec3_t va[9];
      vec2_t vb[4];
      logic [11:0] res, r0, expv;
      logic        o, o0;
      int          lat, g;
      bit          busy, stable, stale, timeout;

      va[0] = '{9'd511, 12'h511, 12'h511};
      va[1] = '{9'd0,   12'h000, 12'hFF0};
      va[2] = '{9'd40,  12'h040, 12'hF40};
      va[3] = '{9'd123, 12'h123, 12'h123};
      va[4] = '{9'd9,   12'h009, 12'hFF9};
      va[5] = '{9'd100, 12'h100, 12'h100};
      va[6] = '{9'd305, 12'h305, 12'h305};
      va[7] = '{9'd450, 12'h450, 12'h450};
      va[8] = '{9'd99,  12'h099, 12'hF99};
      vb[0] = '{9'd255, 8'h55, 8'h55, 1'b1};
      vb[1] = '{9'd99,  8'h99, 8'h99, 1'b0};
      vb[2] = '{9'd100, 8'h00, 8'hF0, 1'b1};
      vb[3] = '{9'd5,   8'h05, 8'hF5, 1'b0};

      rst_n = 1'b0;
      drive(0, 1'b0, 9'd0, 1'b0);
      drive(1, 1'b0, 9'd0, 1'b0);
      drive(2, 1'b0, 9'd0, 1'b0);
      #3;
      check("rst_in_ready",  32'(a.in_ready),  1);
      check("rst_out_valid", 32'(a.out_valid), 0);
      check("rst_bcd_out",   32'(a.bcd_out),   0);
      check("rst_ovf",       32'(a.ovf),       0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         conv(0, va[i].din, i % 3, res, o, lat, busy);
`ifdef BCD_BLANK_EN
         expv = va[i].blank;
`else
         expv = va[i].plain;
`endif
         check($sformatf("d3_bcd_%0d", va[i].din), 32'(res), 32'(expv));
         check($sformatf("d3_ovf_%0d", va[i].din), 32'(o), 0);
         check($sformatf("d3_lat_%0d", va[i].din), 32'(lat), 9);
         check($sformatf("d3_busy_%0d", va[i].din), 32'(busy), 0);
      end

      for (int i = 0; i < 4; i++) begin
         conv(1, vb[i].din, 1, res, o, lat, busy);
`ifdef BCD_BLANK_EN
         expv = {4'h0, vb[i].blank};
`else
         expv = {4'h0, vb[i].plain};
`endif
         check($sformatf("d2_bcd_%0d", vb[i].din), 32'(res), 32'(expv));
         check($sformatf("d2_ovf_%0d", vb[i].din), 32'(o), 32'(vb[i].ovf));
      end

      for (int i = 0; i < 2; i++) begin
         conv(2, 9'(1 - i), 0, res, o, lat, busy);
         check($sformatf("w1_bcd_%0d", 1 - i), 32'(res), 32'(1 - i));
         check($sformatf("w1_lat_%0d", 1 - i), 32'(lat), 1);
      end

      // Output held under back-pressure; in_valid pulses must not start a conversion
      drive(0, 1'b1, 9'd77, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 9'd0, 1'b0);
      g = 0;
      while (!a.out_valid && g < 100) begin @(posedge clk); #1; g++; end
      check("stall_reach_done", 32'(a.out_valid), 1);
      r0 = a.bcd_out;
      o0 = a.ovf;
      check("stall_result", 32'(r0), 32'(model3(77)));
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(0, 1'(k % 2), 9'(200 + k), 1'b0);
         @(posedge clk); #1;
         if (a.bcd_out !== r0 || a.ovf !== o0 || !a.out_valid || a.in_ready) stable = 1'b0;
      end
      check("stall_stable", 32'(stable), 1);
      drive(0, 1'b0, 9'd0, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, 9'd0, 1'b0);
      check("release_out_valid", 32'(a.out_valid), 0);
      check("release_in_ready",  32'(a.in_ready),  1);
      @(posedge clk); #1;
      check("release_stay_idle", 32'(a.in_ready), 1);

      // Asynchronous reset in the middle of SHIFT
      drive(0, 1'b1, 9'd300, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 9'd0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("rst_shift_out_valid", 32'(a.out_valid), 0);
      check("rst_shift_bcd",       32'(a.bcd_out),   0);
      check("rst_shift_in_ready",  32'(a.in_ready),  1);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      stale = 1'b0;
      repeat (15) begin @(posedge clk); #1; if (a.out_valid) stale = 1'b1; end
      check("rst_shift_no_stale", 32'(stale), 0);

      // Asynchronous reset while holding a result in DONE
      drive(0, 1'b1, 9'd456, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 9'd0, 1'b0);
      g = 0;
      while (!a.out_valid && g < 100) begin @(posedge clk); #1; g++; end
      check("done_bcd_456", 32'(a.bcd_out), 32'(model3(456)));
      #2 rst_n = 1'b0;
      #1;
      check("rst_done_out_valid", 32'(a.out_valid), 0);
      check("rst_done_bcd",       32'(a.bcd_out),   0);
      @(posedge clk); #1 rst_n = 1'b1;
      conv(0, 9'd123, 0, res, o, lat, busy);
      check("post_rst_123", 32'(res), 32'(model3(123)));

      // Back-to-back sweep with random output stalls
      timeout  = 1'b0;
      sweep_on = 1'b1;
      for (int v = 0; v < 512; v++) begin
         a.in_valid = 1'b1;
         a.in_data  = 9'(v);
         g = 0;
         while (!a.in_ready && g < 200) begin tick(); g++; end
         if (g >= 200) timeout = 1'b1;
         tick();
      end
      a.in_valid = 1'b0;
      g = 0;
      while (out_obs.size() < 512 && g < 20000) begin tick(); g++; end
      sweep_on    = 1'b0;
      a.out_ready = 1'b0;
      check("sweep_timeout", 32'(timeout), 0);
      check("sweep_count", 32'(out_obs.size()), 512);
      for (int i = 0; i < out_obs.size() && i < 512; i++) begin
         check($sformatf("sweep_%0d", i), 32'(out_obs[i]), 32'({1'b0, model3(i)}));
      end
      check("sweep_min_gap_ge_11", 32'(min_gap >= 11), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
